fft_wm_ctrl: RTL and testbench

Sequencer for one radix-2 DIF FFT stage's twiddle multiplier. It counts incoming samples within a frame and generates the twiddle ROM address and sample index for the shared complex multiplier. It delay-matches a valid strobe through the ROM and multiplier latency and flags frame completion. It sits between the butterfly stage output and the twiddle-multiply instance, one per stage.

---
 rtl/fft_wm_ctrl_pkg.sv | 10 +
 rtl/fft_ctrl_delay.sv | 21 ++
 rtl/fft_wm_ctrl.sv | 116 +++++++++++
 tb/tb_fft_wm_ctrl.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/fft_wm_ctrl_pkg.sv
// fft_wm_ctrl_pkg: FSM state encoding, default latencies and address-width helper
// shared by the twiddle-multiplier sequencer.
package fft_wm_ctrl_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2} state_t;
    localparam int DEF_ROM_LATENCY = 1;
    localparam int DEF_WM_LATENCY = 4;
    function automatic int addr_w(input int nlog2);
        return nlog2 - 1;
    endfunction
endpackage

// File: rtl/fft_ctrl_delay.sv
// fft_ctrl_delay: WIDTH-bit shift register of DEPTH stages (DEPTH >= 1), async active-high reset.
module fft_ctrl_delay #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);
    logic [WIDTH-1:0] sr [DEPTH];
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) sr[i] <= '0;
        end else begin
            sr[0] <= d;
            for (int i = 1; i < DEPTH; i++) sr[i] <= sr[i-1];
        end
    end
    assign q = sr[DEPTH-1];
endmodule

// File: rtl/fft_wm_ctrl.sv
// fft_wm_ctrl: per-stage DIF FFT twiddle sequencer with valid/index delay matching.
// Optional FFT_WM_CTRL_UNITY_EN adds tw_unity_o (W=1 flag aligned with mul_valid_o).
module fft_wm_ctrl
    import fft_wm_ctrl_pkg::*;
#(
    parameter int FFT_N       = 1024,
    parameter int NLOG2       = 10,
    parameter int STAGE       = 0,
    parameter int ROM_LATENCY = DEF_ROM_LATENCY,
    parameter int WM_LATENCY  = DEF_WM_LATENCY
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      start_i,
    input  logic                      valid_i,
    output logic [addr_w(NLOG2)-1:0]  tw_addr_o,
    output logic [NLOG2-1:0]          ctr_o,
    output logic                      mul_valid_o,
    output logic                      valid_o,
    output logic [NLOG2-1:0]          idx_o,
    output logic                      frame_done_o,
    output logic                      busy_o,
    output logic                      err_o
`ifdef FFT_WM_CTRL_UNITY_EN
    ,
    output logic                      tw_unity_o
`endif
);
    localparam int AW = addr_w(NLOG2);
    localparam int DR = ROM_LATENCY + WM_LATENCY;
    localparam logic [NLOG2-1:0] KMASK = NLOG2'((FFT_N >> STAGE) - 1);
    localparam logic [NLOG2-1:0] HALF = NLOG2'(FFT_N >> (STAGE + 1));
    localparam logic [NLOG2-1:0] LAST = NLOG2'(FFT_N - 1);
`ifdef FFT_WM_CTRL_UNITY_EN
    localparam int XW = NLOG2 + 2;
`else
    localparam int XW = NLOG2 + 1;
`endif

    state_t state;
    logic [NLOG2-1:0] n, cur, k;
    logic [7:0] dcnt;
    logic accept, unity;
    logic [AW-1:0] addr;
    logic [XW-1:0] s1, s2;
    logic [NLOG2:0] s3;

    assign accept = valid_i && (start_i || state == RUN);
    assign cur = start_i ? '0 : n;
    assign k = cur & KMASK;
    assign unity = k < HALF;
    assign addr = unity ? '0 : AW'((k - HALF) << STAGE);
    assign busy_o = state != IDLE;

    // start_i wins in every state; only a start seen in RUN is an error
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= IDLE;
            n <= '0;
            dcnt <= '0;
            err_o <= 1'b0;
        end else if (start_i) begin
            state <= RUN;
            n <= valid_i ? NLOG2'(1) : '0;
            err_o <= err_o || state == RUN;
        end else if (state == RUN && valid_i) begin
            state <= (n == LAST) ? DRAIN : RUN;
            n <= n + 1'b1;
            dcnt <= '0;
        end else if (state == DRAIN) begin
            state <= (dcnt == 8'(DR - 1)) ? IDLE : DRAIN;
            dcnt <= dcnt + 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            s1 <= '0;
            tw_addr_o <= '0;
        end else begin
`ifdef FFT_WM_CTRL_UNITY_EN
            s1 <= {unity, cur, accept};
`else
            s1 <= {cur, accept};
`endif
            if (accept) tw_addr_o <= addr;
        end
    end

    fft_ctrl_delay #(.WIDTH(XW), .DEPTH(ROM_LATENCY)) u_rom_dly (
        .clk_i(clk_i), .rst_i(rst_i), .d(s1), .q(s2)
    );

    assign mul_valid_o = s2[0];
    assign ctr_o = s2[NLOG2:1];
`ifdef FFT_WM_CTRL_UNITY_EN
    assign tw_unity_o = s2[XW-1];
`endif

    // last multiplier stage is the output register so frame_done_o can be registered alongside
    fft_ctrl_delay #(.WIDTH(NLOG2 + 1), .DEPTH(WM_LATENCY - 1)) u_wm_dly (
        .clk_i(clk_i), .rst_i(rst_i), .d(s2[NLOG2:0]), .q(s3)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_o <= 1'b0;
            idx_o <= '0;
            frame_done_o <= 1'b0;
        end else begin
            valid_o <= s3[0];
            idx_o <= s3[NLOG2:1];
            frame_done_o <= s3[0] && s3[NLOG2:1] == LAST;
        end
    end
endmodule

// File: tb/tb_fft_wm_ctrl.sv
// tb_fft_wm_ctrl: two instances (N=16/STAGE=1 and N=8/STAGE=0) checked against a frame-level model.
module tb_fft_wm_ctrl;
    localparam int MAXC = 4096;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic st0 = 1'b0, va0 = 1'b0, st1 = 1'b0, va1 = 1'b0;
    logic [2:0] tw0;
    logic [3:0] ctr0, idx0;
    logic mv0, v0, fd0, b0, e0;
    logic [1:0] tw1;
    logic [2:0] ctr1, idx1;
    logic mv1, v1, fd1, b1, e1;
`ifdef FFT_WM_CTRL_UNITY_EN
    logic un0, un1;
`endif

    always #5 clk = ~clk;

    fft_wm_ctrl #(.FFT_N(16), .NLOG2(4), .STAGE(1)) u0 (
        .clk_i(clk), .rst_i(rst), .start_i(st0), .valid_i(va0), .tw_addr_o(tw0), .ctr_o(ctr0),
        .mul_valid_o(mv0), .valid_o(v0), .idx_o(idx0), .frame_done_o(fd0), .busy_o(b0), .err_o(e0)
`ifdef FFT_WM_CTRL_UNITY_EN
        , .tw_unity_o(un0)
`endif
    );

    fft_wm_ctrl #(.FFT_N(8), .NLOG2(3), .STAGE(0)) u1 (
        .clk_i(clk), .rst_i(rst), .start_i(st1), .valid_i(va1), .tw_addr_o(tw1), .ctr_o(ctr1),
        .mul_valid_o(mv1), .valid_o(v1), .idx_o(idx1), .frame_done_o(fd1), .busy_o(b1), .err_o(e1)
`ifdef FFT_WM_CTRL_UNITY_EN
        , .tw_unity_o(un1)
`endif
    );

    int checks = 0, errors = 0, cyc = 8;
    bit macc [2][MAXC];
    int mid [2][MAXC];
    int mad [2][MAXC];
    int mun [2][MAXC];
    bit armed [2];
    bit merr [2];
    int mn [2];
    int dedge [2] = '{-100, -100};
    int nn [2] = '{16, 8};
    int ss [2] = '{1, 0};
    int done_cnt [2];
    int last_done [2];
    int prev_done [2];

    typedef struct {int d; bit st; bit va; int addr; int un;} vec_t;
    vec_t tbl [24];

    task automatic chk(input string nm, input int a, input int e);
        checks++;
        if (a != e) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d edge=%0d", nm, a, e, cyc);
        end
    endtask

    // frame-level reference: sample numbering and twiddle address from the transform rules
    task automatic model(input int d, input bit s, input bit v);
        bit a;
        int l, k;
        a = v && (s || armed[d]);
        if (s && armed[d]) merr[d] = 1'b1;
        if (s) begin
            armed[d] = 1'b1;
            mn[d] = 0;
        end
        macc[d][cyc] = a;
        if (a) begin
            l = nn[d] >> ss[d];
            k = mn[d] % l;
            mid[d][cyc] = mn[d];
            mad[d][cyc] = (k < l / 2) ? 0 : ((k - l / 2) << ss[d]) % (nn[d] / 2);
            mun[d][cyc] = (k < l / 2) ? 1 : 0;
            mn[d]++;
            if (mn[d] == nn[d]) begin
                armed[d] = 1'b0;
                mn[d] = 0;
                dedge[d] = cyc;
            end
        end
    endtask

    task automatic check_dut(input int d);
        int a_tw, a_mv, a_ctr, a_v, a_idx, a_fd, a_b, a_e, a_un;
        bit em, ev;
        int x;
        x = cyc;
        a_un = 0;
        if (d == 0) begin
            a_tw = int'(tw0); a_mv = int'(mv0); a_ctr = int'(ctr0); a_v = int'(v0);
            a_idx = int'(idx0); a_fd = int'(fd0); a_b = int'(b0); a_e = int'(e0);
`ifdef FFT_WM_CTRL_UNITY_EN
            a_un = int'(un0);
`endif
        end else begin
            a_tw = int'(tw1); a_mv = int'(mv1); a_ctr = int'(ctr1); a_v = int'(v1);
            a_idx = int'(idx1); a_fd = int'(fd1); a_b = int'(b1); a_e = int'(e1);
`ifdef FFT_WM_CTRL_UNITY_EN
            a_un = int'(un1);
`endif
        end
        if (macc[d][x]) chk($sformatf("d%0d_tw_addr", d), a_tw, mad[d][x]);
        em = macc[d][x-1];
        chk($sformatf("d%0d_mul_valid", d), a_mv, int'(em));
        if (em) begin
            chk($sformatf("d%0d_ctr", d), a_ctr, mid[d][x-1]);
`ifdef FFT_WM_CTRL_UNITY_EN
            chk($sformatf("d%0d_unity", d), a_un, mun[d][x-1]);
`endif
        end
        ev = macc[d][x-5];
        chk($sformatf("d%0d_valid", d), a_v, int'(ev));
        if (ev) chk($sformatf("d%0d_idx", d), a_idx, mid[d][x-5]);
        chk($sformatf("d%0d_done", d), a_fd, int'(ev && mid[d][x-5] == nn[d] - 1));
        chk($sformatf("d%0d_busy", d), a_b, int'(armed[d] || (x - dedge[d] < 5)));
        chk($sformatf("d%0d_err", d), a_e, int'(merr[d]));
        if (a_fd != 0) begin
            done_cnt[d]++;
            prev_done[d] = last_done[d];
            last_done[d] = x;
        end
    endtask

    task automatic step(input bit s0, input bit w0, input bit s1, input bit w1);
        st0 = s0; va0 = w0; st1 = s1; va1 = w1;
        model(0, s0, w0);
        model(1, s1, w1);
        @(posedge clk);
        @(negedge clk);
        check_dut(0);
        check_dut(1);
        cyc++;
    endtask

    task automatic idle(input int cnt);
        for (int i = 0; i < cnt; i++) step(0, 0, 0, 0);
    endtask

    task automatic check_zero(input string nm);
        chk({nm, "_v0"}, int'(v0), 0);
        chk({nm, "_mv0"}, int'(mv0), 0);
        chk({nm, "_tw0"}, int'(tw0), 0);
        chk({nm, "_idx0"}, int'(idx0), 0);
        chk({nm, "_busy0"}, int'(b0), 0);
        chk({nm, "_err0"}, int'(e0), 0);
        chk({nm, "_done0"}, int'(fd0), 0);
        chk({nm, "_v1"}, int'(v1), 0);
        chk({nm, "_busy1"}, int'(b1), 0);
    endtask

    // reset lands between edges; all state and in-flight samples are discarded
    task automatic areset();
        #2 rst = 1'b1;
        #1 check_zero("async_rst");
        for (int d = 0; d < 2; d++) begin
            armed[d] = 1'b0; merr[d] = 1'b0; mn[d] = 0; dedge[d] = -100;
            for (int i = 0; i <= cyc; i++) macc[d][i] = 1'b0;
        end
        @(posedge clk);
        @(negedge clk);
        cyc++;
        rst = 1'b0;
    endtask

    initial begin
        int a0 [16] = '{0, 0, 0, 0, 0, 2, 4, 6, 0, 0, 0, 0, 0, 2, 4, 6};
        int a1 [8] = '{0, 0, 0, 0, 0, 1, 2, 3};
        int base;
        for (int i = 0; i < 16; i++) tbl[i] = '{0, i == 0, 1'b1, a0[i], 0};
        for (int i = 0; i < 8; i++) tbl[16 + i] = '{1, i == 0, 1'b1, a1[i], (i < 4) ? 1 : 0};

        repeat (3) @(negedge clk);
        check_zero("reset");
        rst = 1'b0;

        for (int i = 0; i < 24; i++) begin
            if (tbl[i].d == 0) step(tbl[i].st, tbl[i].va, 0, 0);
            else step(0, 0, tbl[i].st, tbl[i].va);
            chk("tbl_tw_addr", (tbl[i].d == 0) ? int'(tw0) : int'(tw1), tbl[i].addr);
`ifdef FFT_WM_CTRL_UNITY_EN
            if (tbl[i].d == 1 && i > 16) chk("tbl_unity", int'(un1), tbl[i-1].un);
`endif
        end
        idle(8);
        chk("tbl_done_cnt", done_cnt[0] + done_cnt[1], 2);

        base = done_cnt[0];
        for (int i = 0; i < 16; i++) begin
            step(i == 0, 1, 0, 0);
            if (i % 3 == 2) idle(2);
        end
        idle(8);
        chk("gap_done_cnt", done_cnt[0] - base, 1);

        base = done_cnt[0];
        step(1, 1, 0, 0);
        for (int i = 0; i < 6; i++) step(0, 1, 0, 0);
        step(1, 1, 0, 0);
        for (int i = 0; i < 15; i++) step(0, 1, 0, 0);
        idle(8);
        chk("restart_err", int'(e0), 1);
        chk("restart_done_cnt", done_cnt[0] - base, 1);

        base = done_cnt[0];
        for (int f = 0; f < 2; f++)
            for (int i = 0; i < 16; i++) step(i == 0, 1, i == 0, 1);
        idle(8);
        chk("b2b_done_cnt", done_cnt[0] - base, 2);
        chk("b2b_done_gap", last_done[0] - prev_done[0], 16);

        step(1, 1, 1, 1);
        for (int i = 0; i < 4; i++) step(0, 1, 0, 1);
        areset();
        for (int i = 0; i < 8; i++) step(0, 1, 0, 1);

        for (int i = 0; i < 400; i++)
            step($urandom % 16 == 0, $urandom % 4 != 0, $urandom % 16 == 0, $urandom % 4 != 0);
        idle(12);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
